ctrl_seq: RTL and testbench

Multi-cycle fetch/decode sequencer that sits directly upstream of the 16-bit datapath. It fetches instruction words over a req/ack instruction-memory port at the address given by the datapath PC, and presents an issue word on isr. It drives every datapath control strobe (regw, memw, memin, sflag, spi, pcin, pci). The PC register inside the datapath loads every cycle, so the sequencer holds it in non-execute cycles by issuing a hold word.

---
 rtl/ctrl_seq_if.sv | 29 ++
 rtl/ctrl_seq.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ctrl_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_if.sv
// ============================================================================
//  Module      : ctrl_seq_if
//  Description : Instruction-memory req/ack fetch port of the ctrl_seq sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ctrl_seq_if;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ack,
    output imem_data
  );
endinterface

`default_nettype wire

// File: rtl/ctrl_seq.sv
// ============================================================================
//  Module      : ctrl_seq
//  Description : Multi-cycle fetch/decode sequencer driving the 16-bit datapath
//                control strobes. Optional perf counters under CTRL_PERFCNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_seq #(
  parameter logic [15:0] HOLD_WORD   = 16'h0FFF,
  parameter int          ACK_TIMEOUT = 255
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [15:0] pcout,
  ctrl_seq_if.master       imem,
  output logic      [15:0] isr,
  output logic             regw,
  output logic             memw,
  output logic             sflag,
  output logic      [1:0]  memin,
  output logic      [1:0]  spi,
  output logic             pcin,
  output logic             pci,
  output logic             halted,
  output logic             fault
`ifdef CTRL_PERFCNT_EN
  ,
  output logic      [31:0] retired,
  output logic      [31:0] stall_cyc
`endif
);

  localparam logic [2:0] c_ST_FETCH     = 3'd0;
  localparam logic [2:0] c_ST_EXEC      = 3'd1;
  localparam logic [2:0] c_ST_EXT_ADV   = 3'd2;
  localparam logic [2:0] c_ST_EXT_FETCH = 3'd3;
  localparam logic [2:0] c_ST_HALT      = 3'd4;
  localparam logic [2:0] c_ST_FAULT     = 3'd5;

  localparam logic [3:0] c_OP_PUSH  = 4'b1000;
  localparam logic [3:0] c_OP_POP   = 4'b1001;
  localparam logic [3:0] c_OP_CALL  = 4'b1010;
  localparam logic [3:0] c_OP_RET   = 4'b1011;
  localparam logic [3:0] c_OP_PUSHI = 4'b1100;
  localparam logic [3:0] c_OP_BR    = 4'b1101;
  localparam logic [3:0] c_OP_NOP   = 4'b1110;
  localparam logic [3:0] c_OP_HALT  = 4'b1111;

  localparam logic [1:0] c_MEMIN_X    = 2'd0;
  localparam logic [1:0] c_MEMIN_PC1  = 2'd1;
  localparam logic [1:0] c_MEMIN_XISR = 2'd2;
  localparam logic [1:0] c_SPI_HOLD   = 2'd0;
  localparam logic [1:0] c_SPI_INC    = 2'd1;
  localparam logic [1:0] c_SPI_DEC    = 2'd2;

  // Watchdog counter only ever needs to hold ACK_TIMEOUT-1.
  localparam int               c_WD_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  typedef struct packed {
    logic [15:0] isr;
    logic        regw;
    logic        memw;
    logic        sflag;
    logic [1:0]  memin;
    logic [1:0]  spi;
    logic        pcin;
    logic        pci;
  } ctl_t;

  localparam ctl_t c_HOLD_CTL = '{
    isr:   HOLD_WORD,
    regw:  1'b0,
    memw:  1'b0,
    sflag: 1'b0,
    memin: c_MEMIN_X,
    spi:   c_SPI_HOLD,
    pcin:  1'b1,
    pci:   1'b1
  };

  // Controls for the cycle after a first-word ack. For BR this yields the
  // EXT_ADV controls (plain PC increment to reach the second word).
  function automatic ctl_t f_decode(input logic [15:0] w);
    ctl_t c;
    c = c_HOLD_CTL;
    if (!w[15]) begin
      c.isr   = w;
      c.regw  = 1'b1;
      c.sflag = 1'b1;
      c.pci   = 1'b0;
    end else begin
      case (w[15:12])
        c_OP_PUSH: begin
          c.isr   = w;
          c.memin = c_MEMIN_X;
          c.memw  = 1'b1;
          c.spi   = c_SPI_DEC;
          c.pci   = 1'b0;
        end
        c_OP_POP: begin
          c.isr  = {w[15:14], 3'b001, w[10:0]};
          c.regw = 1'b1;
          c.spi  = c_SPI_INC;
          c.pci  = 1'b0;
        end
        c_OP_CALL: begin
          c.isr   = w;
          c.memin = c_MEMIN_PC1;
          c.memw  = 1'b1;
          c.spi   = c_SPI_DEC;
        end
        c_OP_RET: begin
          c.isr  = w;
          c.pcin = 1'b0;
          c.spi  = c_SPI_INC;
        end
        c_OP_PUSHI: begin
          c.isr   = w;
          c.memin = c_MEMIN_XISR;
          c.memw  = 1'b1;
          c.spi   = c_SPI_DEC;
          c.pci   = 1'b0;
        end
        c_OP_BR:  c.pci = 1'b0;
        c_OP_NOP: c.pci = 1'b0;
        default:  c = c_HOLD_CTL;
      endcase
    end
    return c;
  endfunction

  logic [2:0]        r_state;
  logic [3:0]        r_ir_op;
  logic [3:0]        r_ir_cc;
  logic [c_WD_W-1:0] r_wdog;
  ctl_t              r_ctl;
  logic              r_halted;
  logic              r_fault;

  logic [2:0]        w_state_nx;
  logic [c_WD_W-1:0] w_wdog_nx;
  ctl_t              w_ctl_nx;
  logic              w_halted_nx;
  logic              w_fault_nx;
  logic              w_ir_ld;
  logic              w_fetching;
  logic              w_ack;
  logic              w_wd_expire;

  assign w_fetching  = (r_state == c_ST_FETCH) || (r_state == c_ST_EXT_FETCH);
  assign w_ack       = w_fetching && imem.imem_ack;
  assign w_wd_expire = (ACK_TIMEOUT != 0) && (r_wdog == c_WD_LAST);

  assign imem.imem_addr = pcout;
  assign imem.imem_req  = w_fetching && !reset;

  always_comb begin
    w_state_nx  = r_state;
    w_wdog_nx   = '0;
    w_ctl_nx    = c_HOLD_CTL;
    w_halted_nx = r_halted;
    w_fault_nx  = r_fault;
    w_ir_ld     = 1'b0;
    case (r_state)
      c_ST_FETCH, c_ST_EXT_FETCH: begin
        if (w_ack) begin
          if (r_state == c_ST_FETCH) begin
            w_ir_ld    = 1'b1;
            w_ctl_nx   = f_decode(imem.imem_data);
            w_state_nx = (imem.imem_data[15:12] == c_OP_BR) ? c_ST_EXT_ADV : c_ST_EXEC;
          end else begin
            w_ctl_nx.isr = {r_ir_cc, imem.imem_data[11:0]};
            w_state_nx   = c_ST_EXEC;
          end
        end else if (w_wd_expire) begin
          w_state_nx = c_ST_FAULT;
          w_fault_nx = 1'b1;
        end else if (ACK_TIMEOUT != 0) begin
          w_wdog_nx = r_wdog + 1'b1;
        end
      end
      c_ST_EXT_ADV: begin
        w_state_nx = c_ST_EXT_FETCH;
      end
      c_ST_EXEC: begin
        if (r_ir_op == c_OP_HALT) begin
          w_state_nx  = c_ST_HALT;
          w_halted_nx = 1'b1;
        end else begin
          w_state_nx = c_ST_FETCH;
        end
      end
      c_ST_HALT, c_ST_FAULT: begin
        w_state_nx = r_state;
      end
      default: begin
        w_state_nx = c_ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= c_ST_FETCH;
      r_ir_op  <= 4'd0;
      r_ir_cc  <= 4'd0;
      r_wdog   <= '0;
      r_ctl    <= c_HOLD_CTL;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_wdog   <= w_wdog_nx;
      r_ctl    <= w_ctl_nx;
      r_halted <= w_halted_nx;
      r_fault  <= w_fault_nx;
      if (w_ir_ld) begin
        r_ir_op <= imem.imem_data[15:12];
        r_ir_cc <= imem.imem_data[3:0];
      end
    end
  end

  assign isr    = r_ctl.isr;
  assign regw   = r_ctl.regw;
  assign memw   = r_ctl.memw;
  assign sflag  = r_ctl.sflag;
  assign memin  = r_ctl.memin;
  assign spi    = r_ctl.spi;
  assign pcin   = r_ctl.pcin;
  assign pci    = r_ctl.pci;
  assign halted = r_halted;
  assign fault  = r_fault;

`ifdef CTRL_PERFCNT_EN
  logic [31:0] r_retired;
  logic [31:0] r_stall_cyc;

  // HALT/FAULT are neither EXEC nor fetch states, so both counters freeze there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retired   <= 32'd0;
      r_stall_cyc <= 32'd0;
    end else begin
      if (r_state == c_ST_EXEC) begin
        r_retired <= r_retired + 32'd1;
      end
      if (w_fetching && imem.imem_req && !imem.imem_ack) begin
        r_stall_cyc <= r_stall_cyc + 32'd1;
      end
    end
  end

  assign retired   = r_retired;
  assign stall_cyc = r_stall_cyc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctrl_seq.sv
// ============================================================================
//  Module      : tb_ctrl_seq
//  Description : Directed self-checking bench for ctrl_seq (main + watchdog instance).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ctrl_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] pc;

  ctrl_seq_if imem ();
  ctrl_seq_if wimem ();

  logic [15:0] isr;
  logic        regw, memw, sflag, pcin, pci, halted, fault;
  logic [1:0]  memin, spi;

  logic [15:0] wd_isr;
  logic        wd_regw, wd_memw, wd_sflag, wd_pcin, wd_pci, wd_halted, wd_fault;
  logic [1:0]  wd_memin, wd_spi;

`ifdef CTRL_PERFCNT_EN
  logic [31:0] retired, stall_cyc, wd_retired, wd_stall_cyc;
`endif

  ctrl_seq #(.HOLD_WORD(16'h0FFF), .ACK_TIMEOUT(8)) u_dut (
    .clk(clk), .reset(reset), .pcout(pc), .imem(imem.master),
    .isr(isr), .regw(regw), .memw(memw), .sflag(sflag), .memin(memin),
    .spi(spi), .pcin(pcin), .pci(pci), .halted(halted), .fault(fault)
`ifdef CTRL_PERFCNT_EN
    , .retired(retired), .stall_cyc(stall_cyc)
`endif
  );

  ctrl_seq #(.HOLD_WORD(16'h0FFF), .ACK_TIMEOUT(4)) u_wd (
    .clk(clk), .reset(reset), .pcout(16'h0000), .imem(wimem.master),
    .isr(wd_isr), .regw(wd_regw), .memw(wd_memw), .sflag(wd_sflag), .memin(wd_memin),
    .spi(wd_spi), .pcin(wd_pcin), .pci(wd_pci), .halted(wd_halted), .fault(wd_fault)
`ifdef CTRL_PERFCNT_EN
    , .retired(wd_retired), .stall_cyc(wd_stall_cyc)
`endif
  );

  // Stand-in for the datapath PC: loads every cycle from the issued controls.
  always @(posedge clk or posedge reset) begin
    if (reset)
      pc <= 16'h0040;
    else if (!pcin)
      pc <= 16'h0100;
    else if (pci)
      pc <= pc + 16'd1 + {{4{isr[11]}}, isr[11:0]};
    else
      pc <= pc + 16'd1;
  end

  logic [24:0] ctl_vec, wd_vec;
  assign ctl_vec = {isr, regw, memw, sflag, memin, spi, pcin, pci};
  assign wd_vec  = {wd_isr, wd_regw, wd_memw, wd_sflag, wd_memin, wd_spi, wd_pcin, wd_pci};

  function automatic logic [24:0] mk(input logic [15:0] i, input logic rw, input logic mw,
                                     input logic sf, input logic [1:0] mi, input logic [1:0] sp,
                                     input logic pn, input logic pi);
    return {i, rw, mw, sf, mi, sp, pn, pi};
  endfunction

  logic [24:0] c_hold;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word with a single-cycle ack; returns #1 after the ack edge.
  task automatic fetch1(input logic [15:0] w);
    imem.imem_ack  = 1'b1;
    imem.imem_data = w;
    tick();
    imem.imem_ack  = 1'b0;
    imem.imem_data = 16'hxxxx;
  endtask

  logic [15:0] pc0;

  initial begin
    c_hold          = mk(16'h0FFF, 0, 0, 0, 2'd0, 2'd0, 1, 1);
    reset           = 1'b1;
    imem.imem_ack   = 1'b0;
    imem.imem_data  = 16'h0000;
    wimem.imem_ack  = 1'b0;
    wimem.imem_data = 16'h0000;
    repeat (3) tick();

    chk("rst_ctl",    ctl_vec, c_hold);
    chk("rst_req",    imem.imem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault",  fault, 0);
    reset = 1'b0;
    #1;
    chk("req_after_rst", imem.imem_req, 1);
    chk("addr_is_pc",    imem.imem_addr, pc);

    // Zero-wait ALU
    pc0 = pc;
    fetch1(16'h1100);
    chk("alu_exec",     ctl_vec, mk(16'h1100, 1, 0, 1, 2'd0, 2'd0, 1, 0));
    chk("alu_exec_req", imem.imem_req, 0);
    tick();
    chk("alu_back",     ctl_vec, c_hold);
    chk("alu_pc_inc",   pc, pc0 + 16'd1);
    chk("alu_req",      imem.imem_req, 1);

    // Five wait states: PC held, no strobes
    pc0 = pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wait_ctl", ctl_vec, c_hold);
      chk("wait_req", imem.imem_req, 1);
    end
    chk("wait_pc", pc, pc0);
    fetch1(16'hE000);
    chk("nop_pci",  pci, 0);
    chk("nop_wr",   {regw, memw, sflag}, 3'b000);
    tick();

    // Two-word BR
    fetch1(16'hD001);
    chk("br_adv",     ctl_vec, mk(16'h0FFF, 0, 0, 0, 2'd0, 2'd0, 1, 0));
    chk("br_adv_req", imem.imem_req, 0);
    tick();
    chk("br_ext_req", imem.imem_req, 1);
    chk("br_ext_ctl", ctl_vec, c_hold);
    fetch1(16'h0FF0);
    chk("br_exec",    ctl_vec, mk(16'h1FF0, 0, 0, 0, 2'd0, 2'd0, 1, 1));
    tick();
    chk("br_back",    imem.imem_req, 1);

    // POP / CALL / PUSHI / RET
    fetch1(16'h9A00);
    chk("pop_exec", ctl_vec, mk(16'h8A00, 1, 0, 0, 2'd0, 2'd1, 1, 0));
    tick();
    fetch1(16'hA005);
    chk("call_exec", ctl_vec, mk(16'hA005, 0, 1, 0, 2'd1, 2'd2, 1, 1));
    imem.imem_ack  = 1'b1;   // spurious ack while req is low
    imem.imem_data = 16'hF000;
    tick();
    imem.imem_ack  = 1'b0;
    chk("spur_ctl",    ctl_vec, c_hold);
    chk("spur_req",    imem.imem_req, 1);
    chk("spur_halted", halted, 0);
    fetch1(16'hC00F);
    chk("pushi_exec", ctl_vec, mk(16'hC00F, 0, 1, 0, 2'd2, 2'd2, 1, 0));
    tick();
    fetch1(16'hB000);
    chk("ret_pcin", pcin, 0);
    chk("ret_spi",  spi, 2'd1);
    chk("ret_wr",   {regw, memw, sflag}, 3'b000);
    tick();

    // Reset in the middle of a PUSH EXEC cycle
    fetch1(16'h8123);
    chk("push_exec", ctl_vec, mk(16'h8123, 0, 1, 0, 2'd0, 2'd2, 1, 0));
    reset = 1'b1;
    #1;
    chk("push_rst_memw", memw, 0);
    chk("push_rst_spi",  spi, 2'd0);
    chk("push_rst_ctl",  ctl_vec, c_hold);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_req",    imem.imem_req, 1);
    chk("post_rst_flags",  {halted, fault}, 2'b00);
    fetch1(16'h1100);
    chk("post_rst_alu",    ctl_vec, mk(16'h1100, 1, 0, 1, 2'd0, 2'd0, 1, 0));
    tick();

    // HALT is terminal
    fetch1(16'hF000);
    chk("halt_exec_ctl", ctl_vec, c_hold);
    chk("halt_exec_h",   halted, 0);
    tick();
    chk("halted",     halted, 1);
    chk("halted_req", imem.imem_req, 0);
    imem.imem_ack  = 1'b1;
    imem.imem_data = 16'h1100;
    tick();
    tick();
    imem.imem_ack  = 1'b0;
    chk("halted_stay", halted, 1);
    chk("halted_ctl",  ctl_vec, c_hold);

    // Watchdog (ACK_TIMEOUT=4): no ack ever
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    repeat (3) tick();
    chk("wd_nofault_3", wd_fault, 0);
    chk("wd_req_3",     wimem.imem_req, 1);
    tick();
    chk("wd_fault_4",   wd_fault, 1);
    chk("wd_fault_req", wimem.imem_req, 0);
    chk("wd_fault_ctl", wd_vec, c_hold);
    tick();
    chk("wd_fault_stay", wd_fault, 1);

    // Watchdog: ack on the 4th cycle wins
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    repeat (3) tick();
    wimem.imem_ack  = 1'b1;
    wimem.imem_data = 16'h1100;
    tick();
    wimem.imem_ack  = 1'b0;
    chk("wd_race_fault", wd_fault, 0);
    chk("wd_race_exec",  wd_vec, mk(16'h1100, 1, 0, 1, 2'd0, 2'd0, 1, 0));
    tick();
    chk("wd_race_req",   wimem.imem_req, 1);
    chk("wd_race_after", wd_fault, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
